// File: rtl/window_3x3_gen_pkg.sv
// Shared image geometry defaults and counter-width helper for the 3x3 filter pipeline.
package window_3x3_gen_pkg;

  localparam int unsigned IMG_WIDTH_DEF  = 512;
  localparam int unsigned IMG_HEIGHT_DEF = 512;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned WIN_TAPS       = 9;

  // Counter/address width for a range of n values; never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One image line of storage: 1R1W at the same address, read-before-write, async read.
module window_3x3_gen_line_buffer
  import window_3x3_gen_pkg::*;
#(
  parameter int unsigned DEPTH  = IMG_WIDTH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout_c
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are never read before written for an emitted window, so no reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
  end

  assign o_dout_c = r_mem[i_addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: raster pixels in, one window per interior pixel out.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic [DATA_W-1:0] win5,
  output logic [DATA_W-1:0] win6,
  output logic [DATA_W-1:0] win7,
  output logic [DATA_W-1:0] win8,
  output logic [DATA_W-1:0] win9,
  output logic              out_last
);

  localparam int unsigned COL_W = cnt_w(IMG_WIDTH);
  localparam int unsigned ROW_W = cnt_w(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic              r_out_valid;
  logic              r_out_last;
  logic [DATA_W-1:0] r_win [WIN_TAPS];
  logic [DATA_W-1:0] w_tap1;
  logic [DATA_W-1:0] w_tap2;
  logic              w_accept;
  logic              w_interior;

  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  // in_sof forces the current pixel to (0,0), abandoning any partial frame.
  assign w_col      = in_sof ? '0 : r_col;
  assign w_row      = in_sof ? '0 : r_row;
  assign w_interior = (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));

  window_3x3_gen_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (DATA_W),
    .ADDR_W (COL_W)
  ) u_line1 (
    .clk      (clk),
    .i_we     (w_accept),
    .i_addr   (w_col),
    .i_din    (in_pixel),
    .o_dout_c (w_tap1)
  );

  window_3x3_gen_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (DATA_W),
    .ADDR_W (COL_W)
  ) u_line2 (
    .clk      (clk),
    .i_we     (w_accept),
    .i_addr   (w_col),
    .i_din    (w_tap1),
    .o_dout_c (w_tap2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < int'(WIN_TAPS); i++) begin
        r_win[i] <= '0;
      end
    end else if (w_accept) begin
      // Columns shift left; the new column {line row-2, line row-1, new pixel} enters on the right.
      for (int r = 0; r < 3; r++) begin
        r_win[3*r]     <= r_win[3*r+1];
        r_win[3*r + 1] <= r_win[3*r+2];
      end
      r_win[2]    <= w_tap2;
      r_win[5]    <= w_tap1;
      r_win[8]    <= in_pixel;
      r_out_valid <= w_interior;
      r_out_last  <= w_interior && (w_row == ROW_LAST) && (w_col == COL_LAST);
      if (w_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == ROW_LAST) ? '0 : ROW_W'(w_row + ROW_W'(1));
      end else begin
        r_col <= COL_W'(w_col + COL_W'(1));
        r_row <= w_row;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign win1 = r_win[0];
  assign win2 = r_win[1];
  assign win3 = r_win[2];
  assign win4 = r_win[3];
  assign win5 = r_win[4];
  assign win6 = r_win[5];
  assign win7 = r_win[6];
  assign win8 = r_win[7];
  assign win9 = r_win[8];

endmodule
